// File: rtl/opsum_pool_writer.sv
// opsum_pool_writer
//   Takes the PE array's opsum stream for one ofmap channel in raster order.
//   Each psum is requantized to int8 (arithmetic shift, optional ReLU, saturation).
//   With pooling enabled, 2x2/stride-2 max pooling is applied through a half-row
//   line buffer. The resulting bytes are packed little-endian four to a word and
//   written to the output BRAM port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start / finish    start pulse (latches cfg_*), one-cycle completion pulse
//   cfg_*             ofmap width/height, shift, relu, pool, output base address
//   opsum_enable/ready/value   psum handshake from the PE array
//   OARG_*            write-only BRAM port (rdata unused)
module opsum_pool_writer #(
  parameter int PSUM_DATA_SIZE   = 32,
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int CONFIG_W_BIT     = 12,
  parameter int MAX_OFMAP_W      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        finish,
  input  logic [CONFIG_W_BIT-1:0]     cfg_width,
  input  logic [CONFIG_W_BIT-1:0]     cfg_height,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu,
  input  logic                        cfg_pool,
  input  logic [ADDRESS_BITWIDTH-1:0] cfg_base_addr,
  input  logic                        opsum_enable,
  output logic                        opsum_ready,
  input  logic [PSUM_DATA_SIZE-1:0]   opsum_value,
  output logic [ADDRESS_BITWIDTH-1:0] OARG_address,
  output logic [DATA_BITWIDTH-1:0]    OARG_wdata,
  input  logic [DATA_BITWIDTH-1:0]    OARG_rdata,
  output logic                        OARG_e,
  output logic [3:0]                  OARG_we
);

  localparam int LB_DEPTH = MAX_OFMAP_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic signed [PSUM_DATA_SIZE-1:0] SAT_HI = 127;
  localparam logic signed [PSUM_DATA_SIZE-1:0] SAT_LO = -128;
  localparam logic [CONFIG_W_BIT-1:0]       CFG_ONE  = 1;
  localparam logic [ADDRESS_BITWIDTH-3:0]   WORD_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  // latched configuration
  logic [CONFIG_W_BIT-1:0]     width_q, height_q;
  logic [4:0]                  shift_q;
  logic                        relu_q, pool_q;
  logic [ADDRESS_BITWIDTH-1:0] base_q;

  // input position tracking
  logic [CONFIG_W_BIT-1:0]     col_q, row_q;
  logic                        last_q;      // final psum of the pass has been accepted

  // stage 1: requantized byte plus its position
  logic                        s1_valid_q;
  logic signed [7:0]           s1_byte_q;
  logic                        s1_col_odd_q, s1_row_odd_q;
  logic [LB_AW-1:0]            s1_idx_q;

  // pooling state
  logic signed [7:0]           hold_q;      // even-column byte waiting for its partner
  logic signed [7:0]           rd_q;        // registered line-buffer read
  logic signed [7:0]           line_buf [LB_DEPTH];

  // packer
  logic [1:0]                  lane_q;
  logic [23:0]                 pack_q;
  logic [ADDRESS_BITWIDTH-3:0] word_q;

  // registered outputs
  logic                        finish_q;
  logic                        oarg_e_q;
  logic [3:0]                  oarg_we_q;
  logic [ADDRESS_BITWIDTH-1:0] oarg_addr_q;
  logic [DATA_BITWIDTH-1:0]    oarg_wdata_q;

  logic                        accept, flush_go, finish_d, zero_cfg;
  logic signed [PSUM_DATA_SIZE-1:0] shifted;
  logic signed [7:0]           req_byte, pair_max, pooled, out_byte;
  logic                        out_valid, lb_we;
  logic                        unused_rdata;

  assign unused_rdata = ^OARG_rdata;

  assign finish       = finish_q;
  assign OARG_e       = oarg_e_q;
  assign OARG_we      = oarg_we_q;
  assign OARG_address = oarg_addr_q;
  assign OARG_wdata   = oarg_wdata_q;

  assign zero_cfg = (cfg_width == '0) || (cfg_height == '0);
  assign accept   = opsum_enable && opsum_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    opsum_ready = 1'b0;
    flush_go    = 1'b0;
    finish_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = zero_cfg ? DONE : RUN;
      end
      RUN: begin
        opsum_ready = !last_q;
        // last_q set means the final psum is in stage 1 this cycle, so the
        // pipeline is drained once this cycle's write is registered
        if (last_q) state_d = FLUSH;
      end
      FLUSH: begin
        flush_go = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        finish_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- requantization ----------------
  always_comb begin
    shifted = $signed(opsum_value) >>> shift_q;
    if (relu_q && shifted[PSUM_DATA_SIZE-1]) shifted = '0;
    if (shifted > SAT_HI)      req_byte = 8'sd127;
    else if (shifted < SAT_LO) req_byte = -8'sd128;
    else                       req_byte = shifted[7:0];
  end

  // ---------------- pooling / output byte selection ----------------
  always_comb begin
    pair_max  = (hold_q > s1_byte_q) ? hold_q : s1_byte_q;
    pooled    = (rd_q > pair_max) ? rd_q : pair_max;
    // odd column of an odd row closes a 2x2 window; an odd trailing column or
    // row never reaches that position, which is how it gets dropped
    out_valid = s1_valid_q && (!pool_q || (s1_col_odd_q && s1_row_odd_q));
    out_byte  = pool_q ? pooled : s1_byte_q;
    lb_we     = s1_valid_q && pool_q && s1_col_odd_q && !s1_row_odd_q;
  end

  // line buffer: read at the handshake so the value lines up with stage 1
  always_ff @(posedge clk) begin
    if (accept) rd_q <= line_buf[col_q[LB_AW:1]];
    if (lb_we)  line_buf[s1_idx_q] <= pair_max;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q      <= '0;
      height_q     <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      pool_q       <= 1'b0;
      base_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_byte_q    <= '0;
      s1_col_odd_q <= 1'b0;
      s1_row_odd_q <= 1'b0;
      s1_idx_q     <= '0;
      hold_q       <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      word_q       <= '0;
      finish_q     <= 1'b0;
      oarg_e_q     <= 1'b0;
      oarg_we_q    <= 4'b0000;
      oarg_addr_q  <= '0;
      oarg_wdata_q <= '0;
    end else begin
      finish_q   <= finish_d;
      oarg_e_q   <= 1'b0;
      oarg_we_q  <= 4'b0000;
      s1_valid_q <= accept;

      if (state_q == IDLE && start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        shift_q  <= cfg_shift;
        relu_q   <= cfg_relu;
        pool_q   <= cfg_pool;
        base_q   <= cfg_base_addr;
        col_q    <= '0;
        row_q    <= '0;
        last_q   <= 1'b0;
        lane_q   <= '0;
        pack_q   <= '0;
        word_q   <= '0;
      end

      if (accept) begin
        s1_byte_q    <= req_byte;
        s1_col_odd_q <= col_q[0];
        s1_row_odd_q <= row_q[0];
        s1_idx_q     <= col_q[LB_AW:1];
        if (col_q == width_q - CFG_ONE) begin
          col_q <= '0;
          row_q <= row_q + CFG_ONE;
          if (row_q == height_q - CFG_ONE) last_q <= 1'b1;
        end else begin
          col_q <= col_q + CFG_ONE;
        end
      end

      if (s1_valid_q && !s1_col_odd_q) hold_q <= s1_byte_q;

      if (out_valid) begin
        if (lane_q == 2'd3) begin
          oarg_e_q     <= 1'b1;
          oarg_we_q    <= 4'b1111;
          oarg_addr_q  <= base_q + {word_q, 2'b00};
          oarg_wdata_q <= {out_byte, pack_q};
          pack_q       <= '0;
          word_q       <= word_q + WORD_ONE;
        end else begin
          case (lane_q)
            2'd0:    pack_q[7:0]   <= out_byte;
            2'd1:    pack_q[15:8]  <= out_byte;
            default: pack_q[23:16] <= out_byte;
          endcase
        end
        lane_q <= lane_q + 2'd1;
      end

      // partial trailing word: only the filled lanes are enabled, the rest are 0
      if (flush_go && lane_q != 2'd0) begin
        oarg_e_q     <= 1'b1;
        oarg_addr_q  <= base_q + {word_q, 2'b00};
        oarg_wdata_q <= {8'h00, pack_q};
        case (lane_q)
          2'd1:    oarg_we_q <= 4'b0001;
          2'd2:    oarg_we_q <= 4'b0011;
          default: oarg_we_q <= 4'b0111;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opsum_pool_writer.sv
// Testbench for opsum_pool_writer. Expected BRAM writes are derived from a
// whole-frame reference (requantize every psum, take 2x2 window maxima, pack
// bytes) and queued before each pass; a monitor pops one entry per OARG_e.
module tb_opsum_pool_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_height = '0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        cfg_pool = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic        opsum_enable = 1'b0;
  logic        opsum_ready;
  logic [31:0] opsum_value = '0;
  logic [31:0] OARG_address;
  logic [31:0] OARG_wdata;
  logic [31:0] OARG_rdata = '0;
  logic        OARG_e;
  logic [3:0]  OARG_we;

  opsum_pool_writer dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .cfg_pool(cfg_pool), .cfg_base_addr(cfg_base_addr),
    .opsum_enable(opsum_enable), .opsum_ready(opsum_ready), .opsum_value(opsum_value),
    .OARG_address(OARG_address), .OARG_wdata(OARG_wdata), .OARG_rdata(OARG_rdata),
    .OARG_e(OARG_e), .OARG_we(OARG_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  wr_t exp_q[$];
  int  obs_cyc_q[$];
  int  checks = 0;
  int  fails = 0;
  int  fin_cnt = 0;
  int  fin_cyc = -1;
  int  last_e_cyc = -1;
  bit  sb_ignore = 1'b0;
  int  dir_ps[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (finish) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (OARG_e) begin
      last_e_cyc = cyc;
      if (!sb_ignore) begin
        obs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", OARG_address, e.addr);
          check("wr_data", OARG_wdata, e.data);
          check("wr_we", OARG_we, e.we);
          $display("write addr=0x%08h data=0x%08h we=%b cycle=%0d", OARG_address, OARG_wdata, OARG_we, cyc);
        end
      end
    end else begin
      check("we_without_e", OARG_we, 4'b0000);
    end
  end

  // ---------------- reference model ----------------
  function automatic int requant(input int v, input int sh, input bit relu);
    int s;
    s = v >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s;
  endfunction

  function automatic int rand_psum();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom);
      default: return int'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // mode: 0 enable always high, 1 toggling, 2 random with a stray start mid-pass
  task automatic run_pass(input int w, input int h, input int sh, input bit relu,
                          input bit pool, input int base, input int mode);
    int   ps[$];
    int   qv[$];
    int   bytes[$];
    int   src[$];
    int   exp_src[$];
    int   acc_cyc[$];
    int   nb, n, iter, start_cyc, fin0, extra, tmo, bv;
    bit   en, rdy, tog;
    logic [31:0] d;
    logic [7:0]  b8;
    wr_t  item;

    if (dir_ps.size() == w * h) ps = dir_ps;
    else for (int k = 0; k < w * h; k++) ps.push_back(rand_psum());
    dir_ps.delete();

    for (int k = 0; k < w * h; k++) qv.push_back(requant(ps[k], sh, relu));
    if (!pool) begin
      for (int k = 0; k < w * h; k++) begin
        bytes.push_back(qv[k]);
        src.push_back(k);
      end
    end else begin
      for (int i = 0; i < h / 2; i++)
        for (int j = 0; j < w / 2; j++) begin
          bytes.push_back(max4(qv[2*i*w + 2*j], qv[2*i*w + 2*j + 1],
                               qv[(2*i+1)*w + 2*j], qv[(2*i+1)*w + 2*j + 1]));
          src.push_back((2*i+1)*w + 2*j + 1);
        end
    end
    nb = bytes.size();
    for (int k = 0; k < (nb + 3) / 4; k++) begin
      d = '0;
      for (int l = 0; l < 4 && 4*k + l < nb; l++) begin
        bv = bytes[4*k + l];
        b8 = 8'(bv);
        d  = d | ({24'h0, b8} << (8 * l));
      end
      item.addr = 32'(base + 4 * k);
      item.data = d;
      if (4*k + 3 < nb) begin
        item.we = 4'b1111;
        exp_src.push_back(src[4*k + 3]);
      end else begin
        item.we = 4'((1 << (nb % 4)) - 1);
        exp_src.push_back(-1);
      end
      exp_q.push_back(item);
    end

    obs_cyc_q.delete();
    fin0 = fin_cnt;
    @(negedge clk);
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_shift = 5'(sh);
    cfg_relu = relu; cfg_pool = pool; cfg_base_addr = 32'(base);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    // configuration must be held internally from the start pulse onward
    cfg_width = 12'($urandom_range(0, 70)); cfg_height = 12'($urandom_range(0, 70));
    cfg_shift = 5'($urandom); cfg_relu = ~relu; cfg_pool = ~pool; cfg_base_addr = $urandom;

    n = 0; iter = 0; tog = 1'b1;
    while (n < w * h && iter < 20000) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = tog;
        default: en = ($urandom_range(0, 9) < 7);
      endcase
      tog = ~tog;
      start = (mode == 2 && iter == 3);
      opsum_enable = en;
      opsum_value  = 32'(ps[n]);
      rdy = opsum_ready;
      @(negedge clk);
      if (en && rdy) begin
        acc_cyc.push_back(cyc - 1);
        n++;
      end
      iter++;
    end
    start = 1'b0;
    check("psums_accepted", n, w * h);

    extra = 0;
    for (int k = 0; k < 4; k++) begin
      opsum_enable = 1'b1;
      opsum_value  = $urandom;
      if (opsum_ready) extra++;
      @(negedge clk);
    end
    opsum_enable = 1'b0;
    check("no_accept_after_last", extra, 0);

    tmo = 0;
    while (fin_cnt == fin0 && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    repeat (3) @(negedge clk);
    check("finish_pulses", fin_cnt - fin0, 1);
    check("writes_pending", exp_q.size(), 0);
    check("write_count", obs_cyc_q.size(), exp_src.size());
    for (int k = 0; k < obs_cyc_q.size() && k < exp_src.size(); k++) begin
      if (exp_src[k] >= 0) check("write_latency", obs_cyc_q[k], acc_cyc[exp_src[k]] + 2);
      else                 check("flush_cycle", obs_cyc_q[k], acc_cyc[w*h - 1] + 3);
    end
    if (w * h == 0) check("zero_finish_cycle", fin_cyc, start_cyc + 2);
    else            check("finish_after_last_psum", fin_cyc > acc_cyc[w*h - 1], 1);
    if (nb > 0) check("finish_after_write", fin_cyc > last_e_cyc, 1);
    $display("pass W=%0d H=%0d shift=%0d relu=%0d pool=%0d base=0x%0h bytes=%0d done", w, h, sh, relu, pool, base, nb);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_ready"}, opsum_ready, 0);
    check({tag, "_e"}, OARG_e, 0);
    check({tag, "_we"}, OARG_we, 0);
    check({tag, "_addr"}, OARG_address, 0);
    check({tag, "_wdata"}, OARG_wdata, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fin_before;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    dir_ps = '{1, -2, 127, 300};
    run_pass(4, 1, 0, 1'b0, 1'b0, 32'h100, 0);
    dir_ps = '{256, -80, 2032};
    run_pass(3, 1, 4, 1'b1, 1'b0, 32'h200, 0);
    dir_ps = '{1, 5, 3, 2, 4, 0, 9, -1};
    run_pass(4, 2, 0, 1'b0, 1'b1, 32'h300, 0);
    run_pass(5, 3, 0, 1'b0, 1'b1, 32'h400, 1);
    run_pass(0, 8, 0, 1'b0, 1'b0, 32'h500, 0);

    // abort a W=8,H=8 pass with reset part-way through
    sb_ignore = 1'b1;
    cfg_width = 12'd8; cfg_height = 12'd8; cfg_shift = 5'd0;
    cfg_relu = 1'b0; cfg_pool = 1'b0; cfg_base_addr = 32'h600;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opsum_enable = 1'b1;
    repeat (21) begin
      opsum_value = $urandom;
      @(negedge clk);
    end
    rst = 1'b1;
    opsum_enable = 1'b0;
    exp_q.delete();
    fin_before = fin_cnt;
    @(negedge clk);
    check_outputs_zero("abort");
    sb_ignore = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_finish", fin_cnt, fin_before);
    run_pass(8, 8, 0, 1'b0, 1'b0, 32'h600, 0);

    for (int r = 0; r < 12; r++) begin
      int w, h;
      w = (r == 5) ? 64 : $urandom_range(1, 17);
      h = $urandom_range(1, 9);
      run_pass(w, h, $urandom_range(0, 31) % ((r % 3 == 0) ? 32 : 6), 1'($urandom),
               1'($urandom), $urandom_range(0, 16383) * 4, r % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/opsum_pool_writer.md
# opsum_pool_writer

Downstream consumer of the PE array's opsum output bus. It accepts psums in raster order for one ofmap channel and requantizes each to int8 (arithmetic shift, optional ReLU, saturation). It optionally applies 2x2/stride-2 max pooling, packs four bytes per word and writes the words into the output BRAM port (OARG_*). It fills the pooling slot of the accelerator top level and runs alongside the top controller, which starts it and waits for its `finish`.

## Interface
Parameters:
- PSUM_DATA_SIZE, 32, opsum width (signed)
- ADDRESS_BITWIDTH, 32, BRAM byte-address width
- DATA_BITWIDTH, 32, BRAM data width (4 byte lanes)
- CONFIG_W_BIT, 12, width of ofmap dimension fields
- MAX_OFMAP_W, 64, largest supported cfg_width; sets the line buffer depth to MAX_OFMAP_W/2 bytes

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a pass (ignored unless IDLE)
- finish  out  1  one-cycle pulse when the pass is complete
- cfg_width  in  CONFIG_W_BIT  ofmap width W (psums per row), 0..MAX_OFMAP_W
- cfg_height  in  CONFIG_W_BIT  ofmap height H (rows)
- cfg_shift  in  5  requant right-shift amount
- cfg_relu  in  1  1 = clamp negatives to 0
- cfg_pool  in  1  1 = 2x2 stride-2 max pooling
- cfg_base_addr  in  ADDRESS_BITWIDTH  word-aligned byte address of the first output word
- opsum_enable  in  1  psum valid from PE array
- opsum_ready  out  1  block can accept a psum
- opsum_value  in  PSUM_DATA_SIZE  psum value
- OARG_address  out  ADDRESS_BITWIDTH  BRAM byte address
- OARG_wdata  out  DATA_BITWIDTH  BRAM write data
- OARG_rdata  in  DATA_BITWIDTH  unused (write-only port)
- OARG_e  out  1  BRAM enable
- OARG_we  out  4  byte write enables, bit k covers wdata[8k+7:8k]

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start when W≠0 and H≠0. IDLE -> DONE on start when W=0 or H=0; no writes occur in that case.
- RUN: opsum_ready=1. A transfer occurs when opsum_enable && opsum_ready. The block counts column and row of each accepted psum.
- RUN -> FLUSH when the W*H-th psum is accepted and the pipeline drains. FLUSH -> DONE. DONE -> IDLE.
- Requant: s = opsum_value >>> cfg_shift (arithmetic). If cfg_relu and s<0, s=0. Then saturate to [-128,127].
- Pool off: every requantized byte is an output byte.
- Pool on:
  - Column pairs (2j, 2j+1) reduce to a signed max.
  - Even rows store the pair max in line buffer entry j.
  - Odd rows compute max(buffer[j], pair max), which is an output byte.
  - An odd W drops the last column. An odd H drops the last row. The dropped psums are still accepted.
- Output count N = W*H with pool off, or floor(W/2)*floor(H/2) with pool on.
- Packing: output byte n goes to word n/4, lane n%4 (little-endian).
- A full word is written with OARG_we=4'b1111 at OARG_address = cfg_base_addr + 4*(n/4).
- FLUSH: if N%4≠0, the partial word is written with only the valid lanes set in OARG_we (e.g. N%4=1 gives 4'b0001). Unused lanes of wdata are 0. Otherwise FLUSH writes nothing.
- Config is latched at start; changes to cfg_* during a pass have no effect.

## Timing
- Reset values: finish=0, opsum_ready=0, OARG_e=0, OARG_we=0, OARG_address=0, OARG_wdata=0. FSM goes to IDLE and all counters clear. Line buffer contents are don't-care.
- rst mid-pass aborts immediately: no further writes and no finish pulse.
- Latency: handshake in cycle c; requant register valid in c+1; write for the word completed by that byte visible (OARG_e=1) in c+2.
- OARG_e and OARG_we are high for exactly one cycle per word, and OARG_we=0 whenever OARG_e=0. Throughput is one psum per cycle with no stalls.
- The FLUSH write, if any, occurs in the cycle after the last full-word write slot.
- finish pulses in DONE, exactly one cycle, at least one cycle after the last OARG_e.
- A zero-size start gives finish 2 cycles after the start cycle.
- start while not IDLE is ignored.
- opsum_enable while not in RUN is ignored; no transfer occurs.

## Test plan
- W=4,H=1, pool off, shift=0, relu=0, psums 1,-2,127,300 -> one write at base, wdata=0x7F7FFE01, we=4'b1111, finish 1 pulse.
- W=3,H=1, shift=4, relu=1, psums 0x100,-0x50,0x7F0 -> bytes 0x10,0x00,0x7F. FLUSH writes wdata=0x007F0010, we=4'b0111.
- W=4,H=2, pool on, psums row0 1,5,3,2 / row1 4,0,9,-1 -> single partial write, bytes 5,9, we=4'b0011, wdata=0x00000905.
- W=5,H=3, pool on, opsum_enable toggling every other cycle -> exactly 15 psums accepted, 2 output bytes (odd column/row dropped), finish after final psum.
- W=0,H=8, start -> no OARG_e, finish exactly 2 cycles after start.
- Assert rst during RUN of W=8,H=8 -> outputs zero next cycle, no finish. A fresh start then runs the full pass correctly at cfg_base_addr.
